// File: rtl/bram_pkg.sv
// Shared types and constants for the block RAM arbiter slice.
package bram_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_MASK_W = 4;

  // Requester index: 0 = instruction fetch, 1 = load/store.
  typedef logic port_id_t;

  // One requester's RAM access, bundled so the grant mux selects it as a unit.
  typedef struct packed {
    logic [RAM_ADDR_W-1:0] addr;
    logic                  wren;
    logic [RAM_DATA_W-1:0] wdata;
    logic [RAM_MASK_W-1:0] wmask;
  } bram_req_t;

  // Convert a one-hot (or zero) two-port grant into a port index.
  function automatic port_id_t grant_to_id(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant generator: round-robin, or port 0 wins when fixed is set.
module rr_arb2
  import bram_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  input  logic       fixed,
  output logic [1:0] grant
);

  // Pick one requester; on a conflict favour the port that was not served last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (fixed || (last_grant == 1'b1)) grant = 2'b01;
        else                               grant = 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one block_ram between instruction fetch (port 0) and load/store (port 1).
//
// Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i]
// are both high. req_ready is combinational, one-hot or zero, and never high
// for a port without req_valid. A requester must hold valid until granted.
// Responses have no backpressure: rsp_valid[i] pulses for exactly one cycle,
// one cycle after the grant, and rsp_data is only meaningful in that cycle.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [RAM_ADDR_W-1:0] req_addr0,
  input  logic [RAM_ADDR_W-1:0] req_addr1,
  input  logic                  req_wren0,
  input  logic                  req_wren1,
  input  logic [RAM_DATA_W-1:0] req_wdata0,
  input  logic [RAM_DATA_W-1:0] req_wdata1,
  input  logic [RAM_MASK_W-1:0] req_wmask0,
  input  logic [RAM_MASK_W-1:0] req_wmask1,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [RAM_DATA_W-1:0] rsp_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_wren,
  output logic [RAM_DATA_W-1:0] ram_wdata,
  output logic [RAM_MASK_W-1:0] ram_wmask,
  input  logic [RAM_DATA_W-1:0] ram_rdata,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  bram_req_t  w_req0;
  bram_req_t  w_req1;
  bram_req_t  w_sel;
  logic [1:0] w_grant;
  port_id_t   w_grant_id;
  logic       w_fixed;

  port_id_t             r_last_grant;
  port_id_t             r_rsp_owner;
  logic                 r_rsp_pending;
  logic [CNT_WIDTH-1:0] r_conflict_count;

  assign w_req0     = '{addr: req_addr0, wren: req_wren0, wdata: req_wdata0, wmask: req_wmask0};
  assign w_req1     = '{addr: req_addr1, wren: req_wren1, wdata: req_wdata1, wmask: req_wmask1};
  assign w_fixed    = (FIXED_PRIORITY != 0);
  assign w_grant_id = grant_to_id(w_grant);

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .fixed      (w_fixed),
    .grant      (w_grant)
  );

  // Route the granted port's access to the RAM; an idle cycle drives all zeros.
  always_comb begin
    w_sel = '0;
    if (w_grant[1])      w_sel = w_req1;
    else if (w_grant[0]) w_sel = w_req0;
  end

  assign req_ready = w_grant;
  assign ram_cs    = |w_grant;
  assign ram_addr  = w_sel.addr;
  assign ram_wren  = w_sel.wren;
  assign ram_wdata = w_sel.wdata;
  assign ram_wmask = w_sel.wmask;

  // Remember who was granted: drives fairness and tags the response next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= 1'b0;
      r_last_grant  <= 1'b1;
    end else begin
      r_rsp_pending <= |w_grant;
      if (|w_grant) begin
        r_last_grant <= w_grant_id;
        r_rsp_owner  <= w_grant_id;
      end
    end
  end

  // Steer the single response pulse to the port that owns it.
  always_comb begin
    rsp_valid = 2'b00;
    if (r_rsp_pending) rsp_valid[r_rsp_owner] = 1'b1;
  end

  // RAM read data is already registered inside block_ram, so pass it straight through.
  assign rsp_data = ram_rdata;

  // Count cycles where both ports want the RAM, holding at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_conflict_count <= '0;
    end else if ((req_valid == 2'b11) && (r_conflict_count != CNT_MAX)) begin
      r_conflict_count <= r_conflict_count + CNT_ONE;
    end
  end

  assign conflict_count = r_conflict_count;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: round-robin, fixed-priority and narrow-counter instances.
module tb_bram_arbiter;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- shared stimulus ----------------
  logic [1:0]  req_valid;
  logic [11:0] req_addr0, req_addr1;
  logic        req_wren0, req_wren1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [3:0]  req_wmask0, req_wmask1;
  logic [31:0] zero_rdata;

  assign zero_rdata = 32'h0;

  // ---------------- round-robin instance ----------------
  logic [1:0]  rr_req_ready, rr_rsp_valid;
  logic [31:0] rr_rsp_data, rr_ram_wdata, ram_rdata;
  logic [11:0] rr_ram_addr;
  logic        rr_ram_cs, rr_ram_wren;
  logic [3:0]  rr_ram_wmask;
  logic [15:0] rr_conflict_count;

  bram_arbiter #(.FIXED_PRIORITY(0), .CNT_WIDTH(16)) dut_rr (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wren0(req_wren0), .req_wren1(req_wren1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_wmask0(req_wmask0), .req_wmask1(req_wmask1),
    .req_ready(rr_req_ready), .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data),
    .ram_addr(rr_ram_addr), .ram_cs(rr_ram_cs), .ram_wren(rr_ram_wren),
    .ram_wdata(rr_ram_wdata), .ram_wmask(rr_ram_wmask), .ram_rdata(ram_rdata),
    .conflict_count(rr_conflict_count)
  );

  // ---------------- fixed-priority instance ----------------
  logic [1:0]  fp_req_ready, fp_rsp_valid;
  logic [31:0] fp_rsp_data, fp_ram_wdata;
  logic [11:0] fp_ram_addr;
  logic        fp_ram_cs, fp_ram_wren;
  logic [3:0]  fp_ram_wmask;
  logic [15:0] fp_conflict_count;

  bram_arbiter #(.FIXED_PRIORITY(1), .CNT_WIDTH(16)) dut_fp (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wren0(req_wren0), .req_wren1(req_wren1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_wmask0(req_wmask0), .req_wmask1(req_wmask1),
    .req_ready(fp_req_ready), .rsp_valid(fp_rsp_valid), .rsp_data(fp_rsp_data),
    .ram_addr(fp_ram_addr), .ram_cs(fp_ram_cs), .ram_wren(fp_ram_wren),
    .ram_wdata(fp_ram_wdata), .ram_wmask(fp_ram_wmask), .ram_rdata(zero_rdata),
    .conflict_count(fp_conflict_count)
  );

  // ---------------- 4-bit counter instance ----------------
  logic [1:0]  sat_req_ready, sat_rsp_valid;
  logic [31:0] sat_rsp_data, sat_ram_wdata;
  logic [11:0] sat_ram_addr;
  logic        sat_ram_cs, sat_ram_wren;
  logic [3:0]  sat_ram_wmask;
  logic [3:0]  sat_conflict_count;

  bram_arbiter #(.FIXED_PRIORITY(0), .CNT_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wren0(req_wren0), .req_wren1(req_wren1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_wmask0(req_wmask0), .req_wmask1(req_wmask1),
    .req_ready(sat_req_ready), .rsp_valid(sat_rsp_valid), .rsp_data(sat_rsp_data),
    .ram_addr(sat_ram_addr), .ram_cs(sat_ram_cs), .ram_wren(sat_ram_wren),
    .ram_wdata(sat_ram_wdata), .ram_wmask(sat_ram_wmask), .ram_rdata(zero_rdata),
    .conflict_count(sat_conflict_count)
  );

  // ---------------- block_ram behavioural model (for dut_rr) ----------------
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wdata,
                                             input logic [3:0] mask, input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = wdata << (8 * off);
    r  = old_w;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = sh[8*b +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    mem[4] <= 32'hDEADBEEF;
    mem[1] <= 32'h11223344;
  end

  always @(posedge clock) begin
    if (rr_ram_cs) begin
      if (rr_ram_wren) begin
        mem[rr_ram_addr[11:2]] <= merge_word(mem[rr_ram_addr[11:2]], rr_ram_wdata,
                                             rr_ram_wmask, rr_ram_addr[1:0]);
        ram_rdata <= merge_word(mem[rr_ram_addr[11:2]], rr_ram_wdata,
                                rr_ram_wmask, rr_ram_addr[1:0]);
      end else begin
        ram_rdata <= mem[rr_ram_addr[11:2]];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare response valid; when a response is expected, pop its data from the queue.
  task automatic check_rsp(input string tag, input logic [1:0] exp_valid);
    logic [31:0] exp_d;
    check({tag, "_valid"}, {30'h0, rr_rsp_valid}, {30'h0, exp_valid});
    if (exp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s_queue: observed empty queue expected an entry", tag);
      end else begin
        exp_d = exp_q.pop_front();
        check({tag, "_data"}, rr_rsp_data, exp_d);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid_cycle();
    #4;
  endtask

  // Idle keeps the old payloads so the forced-zero RAM drive is observable.
  task automatic set_idle();
    req_valid = 2'b00;
  endtask

  task automatic set_p0(input logic [11:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    req_addr0 = a; req_wren0 = w; req_wdata0 = d; req_wmask0 = m;
  endtask

  task automatic set_p1(input logic [11:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    req_addr1 = a; req_wren1 = w; req_wdata1 = d; req_wmask1 = m;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] exp_ready;
    logic [1:0] exp_rsp;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req_valid = 2'b00;
    set_p0(12'h0, 1'b0, 32'h0, 4'h0);
    set_p1(12'h0, 1'b0, 32'h0, 4'h0);

    // Reset state
    #3;
    check("rst_rsp_valid", {30'h0, rr_rsp_valid}, 32'h0);
    check("rst_conflict", {16'h0, rr_conflict_count}, 32'h0);
    check("rst_ram_cs", {31'h0, rr_ram_cs}, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Single port 0 read of word 4
    set_p0(12'h010, 1'b0, 32'h0, 4'h0);
    req_valid = 2'b01;
    exp_q.push_back(32'hDEADBEEF);
    mid_cycle();
    check("t1_ready", {30'h0, rr_req_ready}, 32'h1);
    check("t1_ram_cs", {31'h0, rr_ram_cs}, 32'h1);
    check("t1_ram_addr", {20'h0, rr_ram_addr}, 32'h010);
    check("t1_ram_wren", {31'h0, rr_ram_wren}, 32'h0);
    next_cycle();
    set_idle();
    mid_cycle();
    check_rsp("t1_rsp", 2'b01);
    check("t1_idle_ready", {30'h0, rr_req_ready}, 32'h0);
    check("t1_idle_cs", {31'h0, rr_ram_cs}, 32'h0);
    check("t1_idle_addr", {20'h0, rr_ram_addr}, 32'h0);
    next_cycle();

    // Port 1 masked write to byte 1 of word 1, then read it back
    set_p1(12'h005, 1'b1, 32'h000000AB, 4'b0010);
    req_valid = 2'b10;
    exp_q.push_back(32'h1122AB44);
    mid_cycle();
    check_rsp("w_prev", 2'b00);
    check("w_ready", {30'h0, rr_req_ready}, 32'h2);
    check("w_ram_addr", {20'h0, rr_ram_addr}, 32'h005);
    check("w_ram_wren", {31'h0, rr_ram_wren}, 32'h1);
    check("w_ram_wdata", rr_ram_wdata, 32'h000000AB);
    check("w_ram_wmask", {28'h0, rr_ram_wmask}, 32'h2);
    next_cycle();
    set_p1(12'h004, 1'b0, 32'h0, 4'h0);
    exp_q.push_back(32'h1122AB44);
    mid_cycle();
    check_rsp("w_rsp", 2'b10);
    check("r_ready", {30'h0, rr_req_ready}, 32'h2);
    check("r_ram_wren", {31'h0, rr_ram_wren}, 32'h0);
    next_cycle();
    set_idle();
    mid_cycle();
    check_rsp("r_rsp", 2'b10);
    next_cycle();

    // Four conflict cycles; last grant was port 1 so port 0 goes first
    set_p0(12'h010, 1'b0, 32'h0, 4'h0);
    set_p1(12'h004, 1'b0, 32'h0, 4'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rsp   = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      mid_cycle();
      check_rsp($sformatf("rr%0d_rsp", k), exp_rsp);
      check($sformatf("rr%0d_ready", k), {30'h0, rr_req_ready}, {30'h0, exp_ready});
      check($sformatf("fp%0d_ready", k), {30'h0, fp_req_ready}, 32'h1);
      exp_q.push_back((k % 2 == 0) ? 32'hDEADBEEF : 32'h1122AB44);
      next_cycle();
    end
    set_idle();
    mid_cycle();
    check_rsp("rr4_rsp", 2'b10);
    check("rr_conflict4", {16'h0, rr_conflict_count}, 32'd4);
    check("fp_conflict4", {16'h0, fp_conflict_count}, 32'd4);
    check("sat_conflict4", {28'h0, sat_conflict_count}, 32'd4);
    check("fp_rsp_valid", {30'h0, fp_rsp_valid}, 32'h1);
    next_cycle();

    // Granted read, then reset the next cycle: its response must vanish
    req_valid = 2'b01;
    mid_cycle();
    check("pre_rst_ready", {30'h0, rr_req_ready}, 32'h1);
    next_cycle();
    reset = 1'b1;
    set_idle();
    #1;
    check("rst_drop_valid", {30'h0, rr_rsp_valid}, 32'h0);
    check("rst_drop_conflict", {16'h0, rr_conflict_count}, 32'h0);
    check("rst_drop_sat", {28'h0, sat_conflict_count}, 32'h0);
    next_cycle();
    check("rst_hold_valid", {30'h0, rr_rsp_valid}, 32'h0);
    reset = 1'b0;

    // After release a conflict must go to port 0 first, then alternate
    req_valid = 2'b11;
    for (int k = 0; k <= 20; k++) begin
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rsp   = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      mid_cycle();
      check_rsp($sformatf("post%0d_rsp", k), exp_rsp);
      check($sformatf("post%0d_ready", k), {30'h0, rr_req_ready}, {30'h0, exp_ready});
      check($sformatf("post%0d_cnt", k), {16'h0, rr_conflict_count}, k);
      check($sformatf("sat%0d_cnt", k), {28'h0, sat_conflict_count}, (k > 15) ? 15 : k);
      exp_q.push_back((k % 2 == 0) ? 32'hDEADBEEF : 32'h1122AB44);
      next_cycle();
    end
    set_idle();
    mid_cycle();
    check_rsp("post_end_rsp", 2'b01);
    check("rr_conflict_end", {16'h0, rr_conflict_count}, 32'd21);
    check("fp_conflict_end", {16'h0, fp_conflict_count}, 32'd21);
    check("sat_conflict_end", {28'h0, sat_conflict_count}, 32'hF);
    next_cycle();
    mid_cycle();
    check_rsp("quiet_rsp", 2'b00);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one block_ram instance between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Each cycle it grants at most one request, drives the RAM tick_* inputs, and routes the registered RAM read data back to the owning requester one cycle later.
- Arbitration is round-robin by default, with a fixed-priority option.
- Keeps a saturating conflict counter for performance monitoring.

Parameters:
- FIXED_PRIORITY, 0, 1 = port 0 always wins a conflict; 0 = round-robin.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clock  in  1  global clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-port request valid, bit i = port i
- req_addr0, req_addr1  in  12  byte address, same encoding as block_ram tick_addr
- req_wren0, req_wren1  in  1  1 = write, 0 = read
- req_wdata0, req_wdata1  in  32  write data, unshifted
- req_wmask0, req_wmask1  in  4  byte write mask
- req_ready  out  2  per-port grant; a transfer occurs when valid & ready
- rsp_valid  out  2  per-port response valid
- rsp_data  out  32  response data, shared by both ports and qualified by rsp_valid
- ram_addr  out  12  to block_ram tick_addr
- ram_cs  out  1  to block_ram tick_cs
- ram_wren  out  1  to block_ram tick_wren
- ram_wdata  out  32  to block_ram tick_wdata
- ram_wmask  out  4  to block_ram tick_wmask
- ram_rdata  in  32  from block_ram rdata_ret
- conflict_count  out  CNT_WIDTH  saturating count of cycles with both requests valid

Behaviour:
- Reset (asynchronous, active-high):
  - rsp_valid = 0; rsp_owner = 0; last_grant = 1, so port 0 wins the first conflict; conflict_count = 0.
  - A response pending at reset assertion is dropped and never delivered.
- Grant (combinational from req_valid and last_grant):
  - Only one port valid: that port is granted.
  - Both valid, round-robin: grant the port != last_grant.
  - Both valid, fixed priority: grant port 0.
  - Neither valid: no grant; ram_cs = 0.
  - req_ready is one-hot or zero. It is never asserted for a port whose req_valid = 0.
- RAM drive (combinational):
  - ram_cs = |grant.
  - ram_addr, ram_wren, ram_wdata and ram_wmask are muxed from the granted port.
  - With no grant, these four outputs are forced to 0.
- Registered state on each rising edge with a grant:
  - last_grant <= granted port index.
  - rsp_owner <= granted port index.
- Response timing:
  - rsp_valid[rsp_owner] = 1 in the cycle after the grant; all other rsp_valid bits = 0.
  - Latency is exactly 1 cycle for reads and writes.
  - Read response: rsp_data = word at addr[11:2].
  - Write response: rsp_data = merged word after the byte mask is applied. This is block_ram behaviour, passed through unchanged.
- rsp_data = ram_rdata directly, not re-registered. It is don't-care when rsp_valid = 0.
- No response backpressure: requesters must sink rsp_valid in the cycle it is asserted.
- Throughput: one transfer per cycle in total. Back-to-back grants to the same port are allowed when the other port is idle.
- Starvation bound (round-robin): a port holding req_valid is granted within 2 cycles.
- A requester may change addr, wren, wdata or wmask while not granted. Once valid is asserted it must not be dropped before its grant.
- conflict_count:
  - Increments on every cycle with req_valid == 2'b11.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Simultaneous events: a new grant in the same cycle as an outstanding response is normal pipelining. rsp_owner updates for the new grant, while the current rsp_valid still reflects the previous owner.

Decomposition:
- Shared package bram_pkg holds:
  - RAM_ADDR_W = 12, RAM_DATA_W = 32, RAM_MASK_W = 4.
  - typedef port_id_t (1 bit).
  - A struct bram_req_t bundling addr, wren, wdata and wmask.
- One sub-module is natural: rr_arb2, a 2-input round-robin / fixed-priority grant generator. Inputs: req, last_grant, fixed. Output: one-hot grant.
- bram_arbiter instantiates rr_arb2. The block_ram itself is instantiated by the parent, not inside this block.

Test Plan:
- Single port 0 read, addr 0x010, RAM preloaded with 0xDEADBEEF at word 4 → req_ready = 2'b01 that cycle; next cycle rsp_valid = 2'b01, rsp_data = 0xDEADBEEF.
- Both ports valid for 4 cycles, round-robin → grants 0, 1, 0, 1; rsp_valid pattern 01, 10, 01, 10 lagging by one cycle; conflict_count = 4.
- Same stimulus with FIXED_PRIORITY = 1 → port 0 granted for all 4 cycles; port 1 req_ready = 0 throughout.
- Port 1 write, addr 0x005, wdata 0x000000AB, wmask 4'b0010, old word 0x11223344 → next-cycle rsp_data = 0x1122AB44; a later read of addr 0x004 returns 0x1122AB44.
- Assert reset the cycle after a granted read → rsp_valid goes 0 immediately and the response is never delivered; after release, a conflict grants port 0 first.
- Force conflict_count near saturation (CNT_WIDTH = 4, 20 conflict cycles) → conflict_count holds at 0xF.
